// File: rtl/pc_sp_pkg.sv
// Shared types and defaults for the program-counter / stack-pointer unit.
// The PC source enum is what the priority encoder in pc_sp_unit produces.
package pc_sp_pkg;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_SEQ,
        PC_REL,
        PC_ABS,
        PC_CALL,
        PC_RET
    } pc_src_t;

    localparam logic [63:0] SP_INIT_DEF = 64'h3F9;
    localparam int          SP_STEP_DEF = 2;

endpackage

// File: rtl/ras_lifo.sv
// Circular return-address stack: pushing while full overwrites the oldest
// entry, and the count saturates at RAS_DEPTH.
module ras_lifo #(
    parameter  int XLEN      = 64,
    parameter  int RAS_DEPTH = 8,
    localparam int PTR_W     = $clog2(RAS_DEPTH),
    localparam int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [XLEN-1:0]  i_push_data,
    output logic [XLEN-1:0]  o_top,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_ovf
);

    logic [XLEN-1:0]  r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_top_next;
    logic             w_empty;
    logic             w_full;

    assign w_top_next = r_top + PTR_W'(1);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(RAS_DEPTH));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            // The slot above the top is also the oldest entry once full.
            r_top <= w_top_next;
            if (!w_full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (i_pop && !w_empty) begin
            r_top   <= r_top - PTR_W'(1);
            r_count <= r_count - CNT_W'(1);
        end
    end

    // NOTE: storage has no reset; emptiness is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_rst) begin
            r_mem[w_top_next] <= i_push_data;
        end
    end

    assign o_top   = w_empty ? '0 : r_mem[r_top];
    assign o_count = r_count;
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_ovf   = i_push && w_full;

endmodule

// File: rtl/pc_sp_unit.sv
// PC/SP unit: fixed-priority PC source selection, hardware return-address
// stack with memory fallback on underflow, and an independent stack pointer.
module pc_sp_unit
    import pc_sp_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter int              RAS_DEPTH = 8,
    parameter logic [XLEN-1:0] SP_INIT   = XLEN'(SP_INIT_DEF),
    parameter int              SP_STEP   = SP_STEP_DEF
) (
    input  logic                             W_Clk,
    input  logic                             Reset,
    input  logic                             PC_En,
    input  logic                             Jump_En,
    input  logic                             Jump_Reg,
    input  logic                             Call_En,
    input  logic                             Ret_En,
    input  logic                             SP_Inc,
    input  logic                             SP_Dec,
    input  logic [XLEN-1:0]                  Offset,
    input  logic [XLEN-1:0]                  Target,
    input  logic [XLEN-1:0]                  Mem_RA,
    output logic [XLEN-1:0]                  PC_Out,
    output logic [XLEN-1:0]                  SP_Out,
    output logic [XLEN-1:0]                  RA_Out,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   RAS_Count,
    output logic                             RAS_Empty,
    output logic                             RAS_Full,
    output logic                             RAS_Ovf,
    output logic                             RAS_Hit
);

    pc_src_t         w_src;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf_pulse;
    logic            w_empty;
    logic [XLEN-1:0] w_ra;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_sp;
    logic            r_ovf;
    logic            r_hit;

    // NOTE: default assignment first so every path assigns w_src (no latch).
    always_comb begin
        w_src = PC_HOLD;
        if (Ret_En)        w_src = PC_RET;
        else if (Call_En)  w_src = PC_CALL;
        else if (Jump_Reg) w_src = PC_ABS;
        else if (Jump_En)  w_src = PC_REL;
        else if (PC_En)    w_src = PC_SEQ;
    end

    assign w_push = (w_src == PC_CALL) && !Reset;
    assign w_pop  = (w_src == PC_RET) && !w_empty && !Reset;

    ras_lifo #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk       (W_Clk),
        .i_rst       (Reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (r_pc + XLEN'(1)),
        .o_top       (w_ra),
        .o_count     (RAS_Count),
        .o_empty     (w_empty),
        .o_full      (RAS_Full),
        .o_ovf       (w_ovf_pulse)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge W_Clk) begin
        if (Reset) begin
            r_pc  <= '0;
            r_sp  <= SP_INIT;
            r_ovf <= 1'b0;
            r_hit <= 1'b0;
        end else begin
            r_hit <= w_pop;
            if (w_ovf_pulse) r_ovf <= 1'b1;
            unique case (w_src)
                PC_RET:  r_pc <= w_empty ? Mem_RA : w_ra;
                PC_CALL: r_pc <= Target;
                PC_ABS:  r_pc <= Target;
                PC_REL:  r_pc <= r_pc + Offset;
                PC_SEQ:  r_pc <= r_pc + XLEN'(1);
                default: r_pc <= r_pc;
            endcase
            unique case ({SP_Inc, SP_Dec})
                2'b10:   r_sp <= r_sp + XLEN'(SP_STEP);
                2'b01:   r_sp <= r_sp - XLEN'(SP_STEP);
                default: r_sp <= r_sp;
            endcase
        end
    end

    assign PC_Out    = r_pc;
    assign SP_Out    = r_sp;
    assign RA_Out    = w_ra;
    assign RAS_Empty = w_empty;
    assign RAS_Ovf   = r_ovf;
    assign RAS_Hit   = r_hit;

endmodule

// File: tb/tb_pc_sp_unit.sv
// Directed bench for pc_sp_unit: a queue-based reference model is compared on
// every falling edge, and literal expectations pin the model at key points.
module tb_pc_sp_unit;

    localparam int XLEN  = 64;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [7:0] C_RST  = 8'h80;
    localparam logic [7:0] C_RET  = 8'h40;
    localparam logic [7:0] C_CALL = 8'h20;
    localparam logic [7:0] C_JREG = 8'h10;
    localparam logic [7:0] C_JMP  = 8'h08;
    localparam logic [7:0] C_SEQ  = 8'h04;
    localparam logic [7:0] C_INC  = 8'h02;
    localparam logic [7:0] C_DEC  = 8'h01;
    localparam logic [7:0] C_NONE = 8'h00;

    logic             W_Clk = 1'b0;
    logic             Reset = 1'b0;
    logic             PC_En = 1'b0, Jump_En = 1'b0, Jump_Reg = 1'b0;
    logic             Call_En = 1'b0, Ret_En = 1'b0, SP_Inc = 1'b0, SP_Dec = 1'b0;
    logic [XLEN-1:0]  Offset = '0, Target = '0, Mem_RA = '0;
    logic [XLEN-1:0]  PC_Out, SP_Out, RA_Out;
    logic [CNT_W-1:0] RAS_Count;
    logic             RAS_Empty, RAS_Full, RAS_Ovf, RAS_Hit;

    pc_sp_unit #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) dut (
        .W_Clk(W_Clk), .Reset(Reset), .PC_En(PC_En), .Jump_En(Jump_En),
        .Jump_Reg(Jump_Reg), .Call_En(Call_En), .Ret_En(Ret_En),
        .SP_Inc(SP_Inc), .SP_Dec(SP_Dec), .Offset(Offset), .Target(Target),
        .Mem_RA(Mem_RA), .PC_Out(PC_Out), .SP_Out(SP_Out), .RA_Out(RA_Out),
        .RAS_Count(RAS_Count), .RAS_Empty(RAS_Empty), .RAS_Full(RAS_Full),
        .RAS_Ovf(RAS_Ovf), .RAS_Hit(RAS_Hit)
    );

    always #5 W_Clk = ~W_Clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain PC/SP values and a queue holding the RAS.
    logic [XLEN-1:0] m_pc, m_sp;
    logic [XLEN-1:0] m_ras[$];
    logic            m_ovf, m_hit;
    logic            m_valid = 1'b0;

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_update();
        m_hit = 1'b0;
        if (Reset) begin
            m_pc = '0;
            m_sp = 64'h3F9;
            m_ras.delete();
            m_ovf = 1'b0;
        end else begin
            if (Ret_En) begin
                if (m_ras.size() > 0) begin
                    m_pc  = m_ras.pop_back();
                    m_hit = 1'b1;
                end else begin
                    m_pc = Mem_RA;
                end
            end else if (Call_En) begin
                m_ras.push_back(m_pc + 1);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_pc = Target;
            end else if (Jump_Reg) m_pc = Target;
            else if (Jump_En)      m_pc = m_pc + Offset;
            else if (PC_En)        m_pc = m_pc + 1;
            if (SP_Inc && !SP_Dec)      m_sp = m_sp + 2;
            else if (SP_Dec && !SP_Inc) m_sp = m_sp - 2;
        end
        m_valid = 1'b1;
    endtask

    always @(negedge W_Clk) begin
        if (m_valid) begin
            check("pc",    PC_Out, m_pc);
            check("sp",    SP_Out, m_sp);
            check("ra",    RA_Out, (m_ras.size() > 0) ? m_ras[$] : '0);
            check("count", XLEN'(RAS_Count), XLEN'(m_ras.size()));
            check("empty", XLEN'(RAS_Empty), XLEN'(m_ras.size() == 0));
            check("full",  XLEN'(RAS_Full),  XLEN'(m_ras.size() == DEPTH));
            check("ovf",   XLEN'(RAS_Ovf),   XLEN'(m_ovf));
            check("hit",   XLEN'(RAS_Hit),   XLEN'(m_hit));
        end
    end

    task automatic cyc(input logic [7:0] cmd, input logic [XLEN-1:0] tgt = '0,
                       input logic [XLEN-1:0] off = '0, input logic [XLEN-1:0] mra = '0);
        {Reset, Ret_En, Call_En, Jump_Reg, Jump_En, PC_En, SP_Inc, SP_Dec} = cmd;
        Target = tgt;
        Offset = off;
        Mem_RA = mra;
        @(posedge W_Clk);
        model_update();
        @(negedge W_Clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(C_RST);
        check("rst_pc", PC_Out, 64'h0);
        check("rst_sp", SP_Out, 64'h3F9);
        check("rst_ra", RA_Out, 64'h0);
        check("rst_empty", XLEN'(RAS_Empty), 64'd1);
        check("rst_hit", XLEN'(RAS_Hit), 64'd0);

        repeat (3) cyc(C_SEQ);
        check("seq3_pc", PC_Out, 64'd3);
        check("seq3_sp", SP_Out, 64'h3F9);

        cyc(C_JREG, 64'h10);
        cyc(C_CALL, 64'h40);
        check("call_pc", PC_Out, 64'h40);
        check("call_ra", RA_Out, 64'h11);
        check("call_cnt", XLEN'(RAS_Count), 64'd1);
        cyc(C_RET, '0, '0, 64'hDEAD);
        check("ret_pc", PC_Out, 64'h11);
        check("ret_hit", XLEN'(RAS_Hit), 64'd1);
        check("ret_empty", XLEN'(RAS_Empty), 64'd1);
        cyc(C_NONE);
        check("hit_pulse", XLEN'(RAS_Hit), 64'd0);

        // Nine calls into an eight-deep stack: the first return address is lost.
        cyc(C_RST);
        for (int k = 1; k <= 9; k++) cyc(C_CALL, XLEN'(k) * 64'h100);
        check("ovf_cnt", XLEN'(RAS_Count), 64'd8);
        check("ovf_flag", XLEN'(RAS_Ovf), 64'd1);
        check("ovf_ra", RA_Out, 64'h801);
        for (int k = 8; k >= 1; k--) begin
            cyc(C_RET, '0, '0, 64'hDEAD);
            check("lifo_pc", PC_Out, XLEN'(k) * 64'h100 + 64'h1);
        end
        cyc(C_RET, '0, '0, 64'hDEAD);
        check("underflow_pc", PC_Out, 64'hDEAD);
        check("underflow_hit", XLEN'(RAS_Hit), 64'd0);

        cyc(C_JREG, 64'h21);
        cyc(C_CALL, 64'h50);
        check("prio_top", RA_Out, 64'h22);
        cyc(C_RET | C_CALL | C_JMP, 64'h99, 64'h10, 64'hDEAD);
        check("prio_ret_pc", PC_Out, 64'h22);
        check("prio_ret_cnt", XLEN'(RAS_Count), 64'd0);
        cyc(C_JREG | C_JMP, 64'h77, 64'h5);
        check("prio_abs_pc", PC_Out, 64'h77);

        cyc(C_JREG, 64'h5);
        cyc(C_JMP, '0, 64'hFFFF_FFFF_FFFF_FFFA);
        check("rel_wrap", PC_Out, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(C_SEQ);
        check("seq_wrap", PC_Out, 64'h0);

        cyc(C_INC | C_DEC);
        check("sp_both", SP_Out, 64'h3F9);
        repeat (508) cyc(C_DEC);
        check("sp_one", SP_Out, 64'h1);
        cyc(C_DEC);
        check("sp_wrap", SP_Out, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(C_INC);
        check("sp_unwrap", SP_Out, 64'h1);

        cyc(C_CALL, 64'h300);
        cyc(C_CALL, 64'h310);
        cyc(C_CALL, 64'h320);
        check("pre_rst_cnt", XLEN'(RAS_Count), 64'd3);
        cyc(C_RST | C_CALL, 64'h400);
        check("mid_rst_cnt", XLEN'(RAS_Count), 64'd0);
        check("mid_rst_ovf", XLEN'(RAS_Ovf), 64'd0);
        check("mid_rst_pc", PC_Out, 64'h0);
        cyc(C_RET, '0, '0, 64'hBEEF);
        check("post_rst_ret", PC_Out, 64'hBEEF);
        check("post_rst_hit", XLEN'(RAS_Hit), 64'd0);

        cyc(C_NONE);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
